// File: rtl/store_queue_pkg.sv
// store_queue_pkg: shared widths and pointer-width helper for the store queue.
// Contents:
//   SQ_WIDTH_TAG / SQ_WIDTH_ADDR / SQ_WIDTH_DATA  default entry field widths
//   SQ_WIDTH                                       default log2 of queue depth
//   ptr_width(w)                                   pointer width: index bits plus one wrap bit
//   SQ_PTR_W                                       pointer width for the default depth
package store_queue_pkg;
    localparam int SQ_WIDTH_TAG  = 5;
    localparam int SQ_WIDTH_ADDR = 32;
    localparam int SQ_WIDTH_DATA = 32;
    localparam int SQ_WIDTH      = 3;

    function automatic int ptr_width(input int w);
        return w + 1;
    endfunction

    localparam int SQ_PTR_W = ptr_width(SQ_WIDTH);
endpackage

// File: rtl/store_queue_if.sv
// store_queue_if: bundles the allocate, address/data write, commit, memory and load-forward signals.
// Modports:
//   master  drives i_* (pipeline / testbench side), observes o_*
//   slave   observes i_*, drives o_* (store_queue side)
interface store_queue_if
    import store_queue_pkg::*;
#(
    parameter int WIDTH_TAG  = SQ_WIDTH_TAG,
    parameter int WIDTH_ADDR = SQ_WIDTH_ADDR,
    parameter int WIDTH_DATA = SQ_WIDTH_DATA,
    parameter int WIDTH      = SQ_WIDTH
);
    logic                  i_we;
    logic [WIDTH_TAG-1:0]  i_tag;
    logic [WIDTH-1:0]      o_tail;
    logic                  o_full;
    logic                  o_empty;
    logic                  i_weA;
    logic [WIDTH-1:0]      i_waddrA;
    logic [WIDTH_ADDR-1:0] i_addr;
    logic                  i_weD;
    logic [WIDTH-1:0]      i_waddrD;
    logic [WIDTH_DATA-1:0] i_data;
    logic                  i_commit;
    logic                  i_flush;
    logic                  o_mem_valid;
    logic [WIDTH_ADDR-1:0] o_mem_addr;
    logic [WIDTH_DATA-1:0] o_mem_data;
    logic [WIDTH_TAG-1:0]  o_mem_tag;
    logic                  i_mem_ready;
    logic [WIDTH_ADDR-1:0] i_ld_addr;
    logic [WIDTH-1:0]      i_ld_tail;
    logic                  o_fwd_hit;
    logic [WIDTH_DATA-1:0] o_fwd_data;
    logic                  o_fwd_stall;

    modport master (
        output i_we, i_tag, i_weA, i_waddrA, i_addr, i_weD, i_waddrD, i_data,
               i_commit, i_flush, i_mem_ready, i_ld_addr, i_ld_tail,
        input  o_tail, o_full, o_empty, o_mem_valid, o_mem_addr, o_mem_data,
               o_mem_tag, o_fwd_hit, o_fwd_data, o_fwd_stall
    );

    modport slave (
        input  i_we, i_tag, i_weA, i_waddrA, i_addr, i_weD, i_waddrD, i_data,
               i_commit, i_flush, i_mem_ready, i_ld_addr, i_ld_tail,
        output o_tail, o_full, o_empty, o_mem_valid, o_mem_addr, o_mem_data,
               o_mem_tag, o_fwd_hit, o_fwd_data, o_fwd_stall
    );
endinterface

// File: rtl/store_queue_fwd.sv
// store_queue_fwd: age-ordered youngest-match finder for store-to-load forwarding.
// Ports:
//   v, a, d        per-entry valid / address-known / data-known bits
//   addr, data     per-entry address and data storage
//   head, full     oldest entry index and queue-full flag
//   ld_tail        store tail snapshot of the load (search stops before it)
//   ld_addr        load address
//   hit, fwd_data  forwarding result, stall  load must wait
module store_queue_fwd
    import store_queue_pkg::*;
#(
    parameter int WIDTH_ADDR = SQ_WIDTH_ADDR,
    parameter int WIDTH_DATA = SQ_WIDTH_DATA,
    parameter int WIDTH      = SQ_WIDTH,
    localparam int SIZE      = 2**WIDTH
) (
    input  logic [SIZE-1:0]       v,
    input  logic [SIZE-1:0]       a,
    input  logic [SIZE-1:0]       d,
    input  logic [WIDTH_ADDR-1:0] addr [SIZE],
    input  logic [WIDTH_DATA-1:0] data [SIZE],
    input  logic [WIDTH-1:0]      head,
    input  logic                  full,
    input  logic [WIDTH-1:0]      ld_tail,
    input  logic [WIDTH_ADDR-1:0] ld_addr,
    output logic                  hit,
    output logic [WIDTH_DATA-1:0] fwd_data,
    output logic                  stall
);
    logic [WIDTH-1:0]      cnt;
    logic [WIDTH-1:0]      idx;
    logic                  match;
    logic                  md;
    logic                  unk;
    logic [WIDTH_DATA-1:0] mdata;

    // Walk oldest to youngest so the last match seen is the youngest; an unknown
    // address younger than that match (or anywhere, if none) forces a stall.
    always_comb begin
        cnt   = ld_tail - head;
        idx   = head;
        match = 1'b0;
        md    = 1'b0;
        unk   = 1'b0;
        mdata = '0;
        for (int k = 0; k < SIZE; k++) begin
            idx = head + WIDTH'(k);
            // ld_tail equal to head while full means the whole queue is older than the load
            if (v[idx] && (WIDTH'(k) < cnt || (cnt == '0 && full))) begin
                if (!a[idx]) begin
                    unk = 1'b1;
                end else if (addr[idx] == ld_addr) begin
                    match = 1'b1;
                    md    = d[idx];
                    mdata = data[idx];
                    unk   = 1'b0;
                end
            end
        end
        hit      = match && md && !unk;
        stall    = unk || (match && !md);
        fwd_data = hit ? mdata : '0;
    end
endmodule

// File: rtl/store_queue.sv
// store_queue: circular store queue with commit pointer, in-order memory drain and load forwarding.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      store_queue_if.slave: allocate (i_we/i_tag/o_tail/o_full/o_empty),
//            address/data writes, commit, flush, memory drain (o_mem_*/i_mem_ready),
//            load forwarding (i_ld_addr/i_ld_tail/o_fwd_*)
module store_queue
    import store_queue_pkg::*;
#(
    parameter int WIDTH_TAG  = SQ_WIDTH_TAG,
    parameter int WIDTH_ADDR = SQ_WIDTH_ADDR,
    parameter int WIDTH_DATA = SQ_WIDTH_DATA,
    parameter int WIDTH      = SQ_WIDTH,
    localparam int SIZE      = 2**WIDTH
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    store_queue_if.slave bus
);
    localparam int PW = ptr_width(WIDTH);

    logic [PW-1:0]         head_q, head_d, cptr_q, cptr_d, tail_q, tail_d, cnt;
    logic [SIZE-1:0]       v_q, v_d, a_q, a_d, d_q, d_d, c_q, c_d;
    logic [WIDTH_ADDR-1:0] addr_q [SIZE];
    logic [WIDTH_ADDR-1:0] addr_d [SIZE];
    logic [WIDTH_DATA-1:0] data_q [SIZE];
    logic [WIDTH_DATA-1:0] data_d [SIZE];
    logic [WIDTH_TAG-1:0]  tag_q  [SIZE];
    logic [WIDTH_TAG-1:0]  tag_d  [SIZE];
    logic [WIDTH-1:0]      hi, ti, ci, off;
    logic                  full, empty, mem_valid, commit_ok, pop, alloc;

    assign hi        = head_q[WIDTH-1:0];
    assign ti        = tail_q[WIDTH-1:0];
    assign full      = (hi == ti) && (head_q[WIDTH] != tail_q[WIDTH]);
    assign empty     = head_q == tail_q;
    assign mem_valid = v_q[hi] && a_q[hi] && d_q[hi] && c_q[hi];
    assign commit_ok = bus.i_commit && (cptr_q != tail_q);
    assign pop       = mem_valid && bus.i_mem_ready;
    assign alloc     = bus.i_we && !full && !bus.i_flush;

    always_comb begin
        v_d    = v_q;
        a_d    = a_q;
        d_d    = d_q;
        c_d    = c_q;
        addr_d = addr_q;
        data_d = data_q;
        tag_d  = tag_q;
        off    = '0;
        if (alloc) begin
            v_d[ti]   = 1'b1;
            a_d[ti]   = 1'b0;
            d_d[ti]   = 1'b0;
            c_d[ti]   = 1'b0;
            tag_d[ti] = bus.i_tag;
        end
        if (bus.i_weA && v_q[bus.i_waddrA]) begin
            a_d[bus.i_waddrA]    = 1'b1;
            addr_d[bus.i_waddrA] = bus.i_addr;
        end
        if (bus.i_weD && v_q[bus.i_waddrD]) begin
            d_d[bus.i_waddrD]    = 1'b1;
            data_d[bus.i_waddrD] = bus.i_data;
        end
        ci = cptr_q[WIDTH-1:0];
        if (commit_ok) c_d[ci] = 1'b1;
        if (pop) v_d[hi] = 1'b0;
        head_d = head_q + PW'(pop);
        cptr_d = cptr_q + PW'(commit_ok);
        tail_d = tail_q + PW'(alloc);
        // Flush range starts after this cycle's commit, so the newly committed entry survives.
        cnt = tail_q - cptr_d;
        if (bus.i_flush) begin
            for (int i = 0; i < SIZE; i++) begin
                off = WIDTH'(i) - cptr_d[WIDTH-1:0];
                if (PW'(off) < cnt) v_d[i] = 1'b0;
            end
            tail_d = cptr_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q <= '0;
            cptr_q <= '0;
            tail_q <= '0;
            v_q    <= '0;
            a_q    <= '0;
            d_q    <= '0;
            c_q    <= '0;
        end else begin
            head_q <= head_d;
            cptr_q <= cptr_d;
            tail_q <= tail_d;
            v_q    <= v_d;
            a_q    <= a_d;
            d_q    <= d_d;
            c_q    <= c_d;
        end
    end

    always_ff @(posedge i_clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    store_queue_fwd #(
        .WIDTH_ADDR (WIDTH_ADDR),
        .WIDTH_DATA (WIDTH_DATA),
        .WIDTH      (WIDTH)
    ) u_fwd (
        .v        (v_q),
        .a        (a_q),
        .d        (d_q),
        .addr     (addr_q),
        .data     (data_q),
        .head     (hi),
        .full     (full),
        .ld_tail  (bus.i_ld_tail),
        .ld_addr  (bus.i_ld_addr),
        .hit      (bus.o_fwd_hit),
        .fwd_data (bus.o_fwd_data),
        .stall    (bus.o_fwd_stall)
    );

    assign bus.o_tail      = ti;
    assign bus.o_full      = full;
    assign bus.o_empty     = empty;
    assign bus.o_mem_valid = mem_valid;
    assign bus.o_mem_addr  = addr_q[hi];
    assign bus.o_mem_data  = data_q[hi];
    assign bus.o_mem_tag   = tag_q[hi];
endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: directed self-checking bench for store_queue.
module tb_store_queue;
    logic i_clk;
    logic i_rst_n;
    int   vectors;
    int   miscompares;

    store_queue_if sq ();

    store_queue u_dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (sq.slave)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle;
        sq.i_we        = 1'b0;
        sq.i_tag       = '0;
        sq.i_weA       = 1'b0;
        sq.i_waddrA    = '0;
        sq.i_addr      = '0;
        sq.i_weD       = 1'b0;
        sq.i_waddrD    = '0;
        sq.i_data      = '0;
        sq.i_commit    = 1'b0;
        sq.i_flush     = 1'b0;
        sq.i_mem_ready = 1'b0;
        sq.i_ld_addr   = '0;
        sq.i_ld_tail   = '0;
    endtask

    task automatic pulse_reset;
        idle();
        i_rst_n = 1'b0;
        #1;
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic alloc(input logic [4:0] t);
        sq.i_we  = 1'b1;
        sq.i_tag = t;
        tick();
        sq.i_we  = 1'b0;
    endtask

    task automatic wr_a(input logic [2:0] i, input logic [31:0] ad);
        sq.i_weA    = 1'b1;
        sq.i_waddrA = i;
        sq.i_addr   = ad;
        tick();
        sq.i_weA    = 1'b0;
    endtask

    task automatic wr_d(input logic [2:0] i, input logic [31:0] dt);
        sq.i_weD    = 1'b1;
        sq.i_waddrD = i;
        sq.i_data   = dt;
        tick();
        sq.i_weD    = 1'b0;
    endtask

    task automatic wr_ad(input logic [2:0] i, input logic [31:0] ad, input logic [31:0] dt);
        sq.i_weA    = 1'b1;
        sq.i_waddrA = i;
        sq.i_addr   = ad;
        sq.i_weD    = 1'b1;
        sq.i_waddrD = i;
        sq.i_data   = dt;
        tick();
        sq.i_weA    = 1'b0;
        sq.i_weD    = 1'b0;
    endtask

    task automatic commit;
        sq.i_commit = 1'b1;
        tick();
        sq.i_commit = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        i_rst_n = 1'b0;
        tick();
        tick();
        chk("rst_empty", sq.o_empty, 1);
        chk("rst_full", sq.o_full, 0);
        chk("rst_tail", sq.o_tail, 0);
        chk("rst_mem_valid", sq.o_mem_valid, 0);
        chk("rst_fwd_hit", sq.o_fwd_hit, 0);
        chk("rst_fwd_stall", sq.o_fwd_stall, 0);
        i_rst_n = 1'b1;
        tick();

        // fill to full, ninth allocation ignored
        for (int i = 0; i < 8; i++) alloc(5'(i));
        chk("fill_full", sq.o_full, 1);
        chk("fill_tail", sq.o_tail, 0);
        alloc(5'd9);
        chk("ninth_full", sq.o_full, 1);
        chk("ninth_tail", sq.o_tail, 0);
        wr_ad(3'd0, 32'h100, 32'hAA);
        commit();
        #1;
        chk("full_mem_valid", sq.o_mem_valid, 1);
        chk("full_mem_tag", sq.o_mem_tag, 0);
        sq.i_ld_addr = 32'h100;
        sq.i_ld_tail = 3'd0;
        #1;
        chk("full_range_stall", sq.o_fwd_stall, 1);
        chk("full_range_hit", sq.o_fwd_hit, 0);
        sq.i_ld_tail = 3'd1;
        #1;
        chk("full_e0_hit", sq.o_fwd_hit, 1);
        chk("full_e0_data", sq.o_fwd_data, 32'hAA);
        sq.i_mem_ready = 1'b1;
        tick();
        sq.i_mem_ready = 1'b0;
        chk("pop_full", sq.o_full, 0);
        chk("pop_tail", sq.o_tail, 0);
        chk("pop_empty", sq.o_empty, 0);
        sq.i_flush = 1'b1;
        tick();
        sq.i_flush = 1'b0;
        chk("flush_all_empty", sq.o_empty, 1);
        chk("flush_all_tail", sq.o_tail, 1);

        // single entry drains to memory
        pulse_reset();
        alloc(5'd3);
        wr_ad(3'd0, 32'h100, 32'hAA);
        #1;
        chk("uncommitted_mem_valid", sq.o_mem_valid, 0);
        commit();
        chk("drain_valid", sq.o_mem_valid, 1);
        chk("drain_addr", sq.o_mem_addr, 32'h100);
        chk("drain_data", sq.o_mem_data, 32'hAA);
        chk("drain_tag", sq.o_mem_tag, 3);
        sq.i_mem_ready = 1'b1;
        tick();
        sq.i_mem_ready = 1'b0;
        chk("drain_done_valid", sq.o_mem_valid, 0);
        chk("drain_done_empty", sq.o_empty, 1);
        commit();
        alloc(5'd4);
        wr_ad(3'd1, 32'h200, 32'hBB);
        chk("empty_commit_ignored", sq.o_mem_valid, 0);

        // youngest match forwarding
        pulse_reset();
        alloc(5'd1);
        alloc(5'd2);
        wr_ad(3'd0, 32'h40, 32'h11);
        wr_ad(3'd1, 32'h40, 32'h22);
        sq.i_ld_addr = 32'h40;
        sq.i_ld_tail = 3'd2;
        #1;
        chk("fwd2_hit", sq.o_fwd_hit, 1);
        chk("fwd2_data", sq.o_fwd_data, 32'h22);
        chk("fwd2_stall", sq.o_fwd_stall, 0);
        sq.i_ld_tail = 3'd1;
        #1;
        chk("fwd1_hit", sq.o_fwd_hit, 1);
        chk("fwd1_data", sq.o_fwd_data, 32'h11);
        sq.i_ld_tail = 3'd0;
        #1;
        chk("fwd0_hit", sq.o_fwd_hit, 0);
        chk("fwd0_stall", sq.o_fwd_stall, 0);
        chk("fwd0_data", sq.o_fwd_data, 0);
        sq.i_ld_addr = 32'h44;
        sq.i_ld_tail = 3'd2;
        #1;
        chk("fwd_miss_hit", sq.o_fwd_hit, 0);
        chk("fwd_miss_stall", sq.o_fwd_stall, 0);

        // unknown younger address, then match without data, then data arrives
        pulse_reset();
        alloc(5'd1);
        alloc(5'd2);
        wr_ad(3'd0, 32'h40, 32'h11);
        sq.i_ld_addr = 32'h40;
        sq.i_ld_tail = 3'd2;
        #1;
        chk("unk_stall", sq.o_fwd_stall, 1);
        chk("unk_hit", sq.o_fwd_hit, 0);
        sq.i_ld_tail = 3'd1;
        #1;
        chk("older_only_hit", sq.o_fwd_hit, 1);
        chk("older_only_data", sq.o_fwd_data, 32'h11);
        sq.i_ld_tail = 3'd2;
        wr_a(3'd1, 32'h40);
        chk("nodata_stall", sq.o_fwd_stall, 1);
        chk("nodata_hit", sq.o_fwd_hit, 0);
        wr_d(3'd1, 32'h55);
        chk("data_in_hit", sq.o_fwd_hit, 1);
        chk("data_in_data", sq.o_fwd_data, 32'h55);
        chk("data_in_stall", sq.o_fwd_stall, 0);

        // flush with same-cycle commit and allocate
        pulse_reset();
        for (int i = 0; i < 4; i++) alloc(5'(10 + i));
        commit();
        commit();
        sq.i_flush  = 1'b1;
        sq.i_commit = 1'b1;
        sq.i_we     = 1'b1;
        sq.i_tag    = 5'd20;
        tick();
        idle();
        chk("flush_tail", sq.o_tail, 3);
        for (int i = 0; i < 3; i++) wr_ad(3'(i), 32'(32'h300 + i), 32'(32'h30 + i));
        sq.i_mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("flush_pop_valid", sq.o_mem_valid, 1);
            chk("flush_pop_tag", sq.o_mem_tag, 32'(10 + i));
            tick();
        end
        sq.i_mem_ready = 1'b0;
        #1;
        chk("flush_pop_empty", sq.o_empty, 1);
        chk("flush_pop_done", sq.o_mem_valid, 0);
        commit();
        alloc(5'd21);
        wr_ad(3'd3, 32'h500, 32'h50);
        chk("post_flush_uncommitted", sq.o_mem_valid, 0);
        commit();
        chk("post_flush_valid", sq.o_mem_valid, 1);
        chk("post_flush_tag", sq.o_mem_tag, 21);

        // asynchronous reset mid-operation
        pulse_reset();
        for (int i = 0; i < 3; i++) alloc(5'(1 + i));
        for (int i = 0; i < 3; i++) wr_ad(3'(i), 32'(32'h600 + 4 * i), 32'(32'h60 + i));
        for (int i = 0; i < 3; i++) commit();
        sq.i_ld_addr = 32'h600;
        sq.i_ld_tail = 3'd3;
        #1;
        chk("pre_rst_mem_valid", sq.o_mem_valid, 1);
        chk("pre_rst_fwd_hit", sq.o_fwd_hit, 1);
        chk("pre_rst_tail", sq.o_tail, 3);
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_empty", sq.o_empty, 1);
        chk("async_rst_full", sq.o_full, 0);
        chk("async_rst_tail", sq.o_tail, 0);
        chk("async_rst_mem_valid", sq.o_mem_valid, 0);
        chk("async_rst_fwd_hit", sq.o_fwd_hit, 0);
        chk("async_rst_fwd_stall", sq.o_fwd_stall, 0);
        i_rst_n = 1'b1;
        tick();
        chk("after_rst_empty", sq.o_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH_TAG, 5, ROB tag width
  WIDTH_ADDR, 32, address width
  WIDTH_DATA, 32, store data width
  WIDTH, 3, log2 of depth
  SIZE, 2**WIDTH, entry count (derived, not overridden)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  i_clk  in  1  clock
  i_rst_n  in  1  reset
  i_we  in  1  allocate entry at tail
  i_tag  in  WIDTH_TAG  tag of allocated store
  o_tail  out  WIDTH  index the next allocation receives
  o_full / o_empty  out  1  queue status
  i_weA  in  1  address write
  i_waddrA  in  WIDTH  address write index
  i_addr  in  WIDTH_ADDR  store address
  i_weD  in  1  data write
  i_waddrD  in  WIDTH  data write index
  i_data  in  WIDTH_DATA  store data
  i_commit  in  1  retire oldest uncommitted store
  i_flush  in  1  discard all uncommitted entries
  o_mem_valid  out  1  head entry ready to write memory
  o_mem_addr / o_mem_data / o_mem_tag  out  WIDTH_ADDR / WIDTH_DATA / WIDTH_TAG  head entry fields
  i_mem_ready  in  1  memory accepts head
  i_ld_addr  in  WIDTH_ADDR  load address to check
  i_ld_tail  in  WIDTH  store tail snapshot at load dispatch
  o_fwd_hit  out  1  forwarding data valid
  o_fwd_data  out  WIDTH_DATA  forwarded data
  o_fwd_stall  out  1  load must wait
REQ-003 There SHALL be one clock, i_clk; reset i_rst_n SHALL be asynchronous, active-low.

Function
REQ-004 Pointers head, cptr (commit), tail SHALL be WIDTH+1 bits; the index is the low WIDTH bits; wrap is natural modulo 2**(WIDTH+1).
REQ-005 o_empty SHALL equal (head==tail); o_full SHALL equal (index equal, MSB differ).
REQ-006 i_we with !o_full SHALL set V=1, A=0, D=0, C=0 and tag at tail, then increment tail; i_we while full SHALL be ignored.
REQ-007 i_weA / i_weD SHALL write address+A=1 / data+D=1 into the indexed entry only if V=1; both writes to one index in one cycle SHALL both take effect.
REQ-008 i_commit SHALL set C=1 at cptr and increment cptr only if cptr!=tail; otherwise it is ignored.
REQ-009 o_mem_valid SHALL be combinational: V&A&D&C at head; o_mem_* SHALL show the head fields.
REQ-010 o_mem_valid & i_mem_ready SHALL clear V at head and increment head in that cycle.
REQ-011 i_flush SHALL clear V for every entry from cptr (after any same-cycle commit) to tail and set tail to that cptr; same-cycle i_we SHALL be dropped; same-cycle pop SHALL proceed.
REQ-012 Forwarding search range SHALL be valid entries from head up to, but excluding, i_ld_tail; all outputs combinational.
REQ-013 Youngest in-range entry with A=1 and addr==i_ld_addr: if D=1, o_fwd_hit=1 and o_fwd_data=its data; if D=0, o_fwd_stall=1.
REQ-014 o_fwd_stall SHALL also be 1 if an in-range entry younger than the matching entry (or any, if none matches) has A=0; o_fwd_hit and o_fwd_stall SHALL never both be 1.
REQ-015 If no entry is in range (i_ld_tail==head index, not full), o_fwd_hit=o_fwd_stall=0 and o_fwd_data=0.

Reset
REQ-016 Reset SHALL clear all V/A/D/C bits and head, cptr, tail; outputs: o_empty=1, o_full=0, o_tail=0, o_mem_valid=0, o_fwd_hit=0, o_fwd_stall=0; address, data and tag storage need not reset.
REQ-017 Reset asserted mid-operation SHALL discard all entries, committed included, immediately.

Structure
REQ-018 A shared package SHALL hold the entry field widths and the pointer-width constant (WIDTH+1).
REQ-019 The forwarding priority search SHALL be one sub-module, store_queue_fwd (age-ordered youngest-match finder).

Verification
REQ-020 Fill 8 entries (WIDTH=3) -> o_full=1 and a 9th i_we is ignored; pop 1 -> o_full=0, o_tail=0.
REQ-021 Entry 0 addr 0x100, data 0xAA, committed, i_mem_ready=1 -> o_mem_valid one cycle, o_mem_addr=0x100, o_mem_data=0xAA, then o_empty=1.
REQ-022 Entries 0,1 addr 0x40, data 0x11/0x22, i_ld_tail=2 -> o_fwd_hit=1, o_fwd_data=0x22; i_ld_tail=1 -> o_fwd_data=0x11.
REQ-023 Entry 0 addr 0x40 data 0x11, entry 1 address unknown, i_ld_tail=2, i_ld_addr=0x40 -> o_fwd_stall=1, o_fwd_hit=0.
REQ-024 4 entries allocated, 2 committed, i_flush with i_commit and i_we same cycle -> tail=3, entry 2 committed, entry 3 invalid, no new allocation.
REQ-025 Reset pulsed with 3 committed entries and o_mem_valid=1 -> outputs take REQ-016 values before the next clock edge.
